// File: rtl/dct_2d_stream.sv
// Streaming N x N row/column 2D transform around an external 1D engine, with per-block bypass.
// Optional build macro DCT_LEVEL_SHIFT_EN: inputs are level-shifted to signed before the row pass.
module dct_2d_stream #(
  parameter int N       = 8,
  parameter int IN_W    = 8,
  parameter int OUT_W   = 12,
  parameter int ENG_LAT = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*IN_W-1:0]    in_row,
  input  logic                 bypass,
  output logic [N*OUT_W-1:0]   eng_in,
  input  logic [N*OUT_W-1:0]   eng_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*OUT_W-1:0]   out_row,
  output logic                 busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    DRAIN_R = 3'd1,
    COL     = 3'd2,
    DRAIN_C = 3'd3,
    OUT     = 3'd4
  } state_t;

  // Widen one input sample to engine width (flipping the MSB is the same as subtracting 2^(IN_W-1)).
  function automatic logic [OUT_W-1:0] conv_elem(input logic [IN_W-1:0] x);
`ifdef DCT_LEVEL_SHIFT_EN
    conv_elem = {{(OUT_W-IN_W){~x[IN_W-1]}}, ~x[IN_W-1], x[IN_W-2:0]};
`else
    conv_elem = {{(OUT_W-IN_W){1'b0}}, x};
`endif
  endfunction

  state_t state_q, state_d;

  logic [CW-1:0]      row_cnt_q, row_cnt_d;
  logic [CW-1:0]      col_cnt_q, col_cnt_d;
  logic [CW-1:0]      out_cnt_q, out_cnt_d;
  logic               byp_q, byp_d;
  logic [ENG_LAT-1:0] tag_v_q, tag_v_d;
  logic [CW-1:0]      tag_idx_q [ENG_LAT];
  logic [CW-1:0]      tag_idx_d [ENG_LAT];
  logic [N*OUT_W-1:0] eng_in_q, eng_in_d;
  logic [N*OUT_W-1:0] out_row_q, out_row_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic [N*OUT_W-1:0] row_buf_q [N];
  logic [N*OUT_W-1:0] row_buf_d [N];
  logic [N*OUT_W-1:0] col_buf_q [N];
  logic [N*OUT_W-1:0] col_buf_d [N];

  logic          in_fire_s;
  logic          out_fire_s;
  logic          eff_byp_s;
  logic          tags_empty_s;
  logic          load_out_s;
  logic [CW-1:0] out_sel_s;

  assign in_fire_s    = in_valid & in_ready_q;
  assign out_fire_s   = out_valid_q & out_ready;
  assign eff_byp_s    = (row_cnt_q == '0) ? bypass : byp_q;
  assign tags_empty_s = ~|tag_v_q;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: begin
        if (in_fire_s && (row_cnt_q == LAST)) begin
          state_d = eff_byp_s ? OUT : DRAIN_R;
        end else begin
          state_d = LOAD;
        end
      end
      DRAIN_R: begin
        if (tags_empty_s) begin
          state_d = COL;
        end else begin
          state_d = DRAIN_R;
        end
      end
      COL: begin
        if (col_cnt_q == LAST) begin
          state_d = DRAIN_C;
        end else begin
          state_d = COL;
        end
      end
      DRAIN_C: begin
        if (tags_empty_s) begin
          state_d = OUT;
        end else begin
          state_d = DRAIN_C;
        end
      end
      OUT: begin
        if (out_fire_s && (out_cnt_q == LAST)) begin
          state_d = LOAD;
        end else begin
          state_d = OUT;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Handshake and status outputs follow the upcoming state so they are registered.
  always_comb begin
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == OUT);
    busy_d      = (state_d != LOAD) || (row_cnt_d != '0);
  end

  // Datapath: counters, tag pipe, engine feed, buffer writes and output row selection.
  always_comb begin
    row_cnt_d  = row_cnt_q;
    col_cnt_d  = col_cnt_q;
    out_cnt_d  = out_cnt_q;
    byp_d      = byp_q;
    eng_in_d   = eng_in_q;
    row_buf_d  = row_buf_q;
    col_buf_d  = col_buf_q;
    load_out_s = 1'b0;
    out_sel_s  = '0;

    tag_v_d[0]   = 1'b0;
    tag_idx_d[0] = '0;
    for (int i = ENG_LAT - 1; i > 0; i--) begin
      tag_v_d[i]   = tag_v_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end

    // The pass in flight is implied by the state: drain states never overlap the other pass.
    if (tag_v_q[ENG_LAT-1]) begin
      if ((state_q == COL) || (state_q == DRAIN_C)) begin
        col_buf_d[tag_idx_q[ENG_LAT-1]] = eng_out;
      end else begin
        row_buf_d[tag_idx_q[ENG_LAT-1]] = eng_out;
      end
    end else begin
      row_buf_d = row_buf_q;
    end

    case (state_q)
      LOAD: begin
        if (in_fire_s) begin
          row_cnt_d = (row_cnt_q == LAST) ? '0 : row_cnt_q + 1'b1;
          byp_d     = eff_byp_s;
          if (eff_byp_s) begin
            for (int c = 0; c < N; c++) begin
              col_buf_d[c][row_cnt_q*OUT_W +: OUT_W] = conv_elem(in_row[c*IN_W +: IN_W]);
            end
            load_out_s = (row_cnt_q == LAST);
          end else begin
            for (int c = 0; c < N; c++) begin
              eng_in_d[c*OUT_W +: OUT_W] = conv_elem(in_row[c*IN_W +: IN_W]);
            end
            tag_v_d[0]   = 1'b1;
            tag_idx_d[0] = row_cnt_q;
          end
        end else begin
          row_cnt_d = row_cnt_q;
        end
      end
      DRAIN_R: begin
        col_cnt_d = '0;
      end
      COL: begin
        for (int r = 0; r < N; r++) begin
          eng_in_d[r*OUT_W +: OUT_W] = row_buf_q[r][col_cnt_q*OUT_W +: OUT_W];
        end
        tag_v_d[0]   = 1'b1;
        tag_idx_d[0] = col_cnt_q;
        col_cnt_d    = (col_cnt_q == LAST) ? '0 : col_cnt_q + 1'b1;
      end
      DRAIN_C: begin
        load_out_s = tags_empty_s;
        out_cnt_d  = '0;
      end
      OUT: begin
        if (out_fire_s) begin
          if (out_cnt_q == LAST) begin
            out_cnt_d = '0;
          end else begin
            out_cnt_d  = out_cnt_q + 1'b1;
            load_out_s = 1'b1;
            out_sel_s  = out_cnt_q + 1'b1;
          end
        end else begin
          out_cnt_d = out_cnt_q;
        end
      end
      default: begin
        row_cnt_d = '0;
        col_cnt_d = '0;
        out_cnt_d = '0;
      end
    endcase

    // Output row r gathers element r of every column result.
    if (load_out_s) begin
      for (int c = 0; c < N; c++) begin
        out_row_d[c*OUT_W +: OUT_W] = col_buf_q[c][out_sel_s*OUT_W +: OUT_W];
      end
    end else begin
      out_row_d = out_row_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
      out_cnt_q   <= '0;
      byp_q       <= 1'b0;
      tag_v_q     <= '0;
      eng_in_q    <= '0;
      out_row_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      for (int i = 0; i < ENG_LAT; i++) begin
        tag_idx_q[i] <= '0;
      end
    end else begin
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      out_cnt_q   <= out_cnt_d;
      byp_q       <= byp_d;
      tag_v_q     <= tag_v_d;
      eng_in_q    <= eng_in_d;
      out_row_q   <= out_row_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      for (int i = 0; i < ENG_LAT; i++) begin
        tag_idx_q[i] <= tag_idx_d[i];
      end
    end
  end

  // Transpose buffers hold no state that matters across reset.
  always_ff @(posedge clock) begin
    row_buf_q <= row_buf_d;
    col_buf_q <= col_buf_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign eng_in    = eng_in_q;
  assign busy      = busy_q;

endmodule
